// File: rtl/ct_spsram_ctrl_pkg.sv
// Shared state encoding and read-latency selection for the 256x144 SRAM controller.
// CT_SPSRAM_CTRL_RDATA_FLOP_EN selects a registered sram_q path (read latency 2).
package ct_spsram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

`ifdef CT_SPSRAM_CTRL_RDATA_FLOP_EN
  localparam int RD_LATENCY = 2;
`else
  localparam int RD_LATENCY = 1;
`endif

endpackage

// File: rtl/ct_spsram_rr_arb.sv
// Round-robin arbiter: one-hot grant scanned from the pointer, pointer moves past the grantee.
module ct_spsram_rr_arb #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_vld,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] scan_idx;
  logic             found;
  int               idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    scan_idx  = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      scan_idx = PTR_W'(idx);
      if (!found && req_vld[scan_idx]) begin
        found           = 1'b1;
        grant[scan_idx] = 1'b1;
        grant_idx       = scan_idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ct_spsram_256x144_ctrl.sv
// Sequencer/arbiter for a 256x144 single-port SRAM: array clear, round-robin port sharing, read return.
// CT_SPSRAM_CTRL_RDATA_FLOP_EN (through ct_spsram_ctrl_pkg) registers sram_q for read latency 2.
module ct_spsram_256x144_ctrl
  import ct_spsram_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 144,
  parameter int                    NUM_REQ    = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                           forever_cpuclk,
  input  logic                           cpurst,
  input  logic                           flush_req,
  output logic                           init_busy,
  input  logic [NUM_REQ-1:0]             req_vld,
  input  logic [NUM_REQ-1:0]             req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wmask,
  output logic [NUM_REQ-1:0]             req_rdy,
  output logic [NUM_REQ-1:0]             rsp_vld,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic [ADDR_WIDTH-1:0]          sram_a,
  output logic                           sram_cen,
  output logic                           sram_gwen,
  output logic [DATA_WIDTH-1:0]          sram_wen,
  output logic [DATA_WIDTH-1:0]          sram_d,
  input  logic [DATA_WIDTH-1:0]          sram_q
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   d_q, d_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [NUM_REQ-1:0]      own1_q, own1_d;
  logic [NUM_REQ-1:0]      arb_vld, grant;
  logic                    arb_en, any_grant;
  logic                    sel_wr;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata, sel_wmask;

  assign arb_en    = (state_q != ST_CLEAR);
  assign arb_vld   = arb_en ? req_vld : '0;
  assign any_grant = |grant;
  assign req_rdy   = grant;

  ct_spsram_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk     (forever_cpuclk),
    .rst     (cpurst),
    .req_vld (arb_vld),
    .advance (any_grant),
    .grant   (grant)
  );

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wmask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_wr    = req_wr[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_wmask = req_wmask[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Address/data pins keep their last driven value whenever the port is idle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    own1_d    = '0;
    init_busy = 1'b0;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = a_q;
    sram_d    = d_q;
    case (state_q)
      ST_CLEAR: begin
        init_busy = 1'b1;
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = cnt_q;
        sram_d    = INIT_VAL;
        cnt_d     = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == '1) state_d = ST_IDLE;
      end
      default: begin
        if (any_grant) begin
          sram_cen = 1'b0;
          sram_a   = sel_addr;
          if (sel_wr) begin
            sram_gwen = 1'b0;
            sram_wen  = ~sel_wmask;
            sram_d    = sel_wdata;
          end else begin
            own1_d = grant;
          end
        end
        state_d = any_grant ? ST_RUN : ST_IDLE;
        if (flush_req) state_d = ST_CLEAR;
      end
    endcase
    a_d = sram_a;
    d_d = sram_d;
  end

  assign rdata_d = (|own1_q) ? sram_q : rdata_q;

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      a_q     <= '0;
      d_q     <= '0;
      own1_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      d_q     <= d_d;
      own1_q  <= own1_d;
      rdata_q <= rdata_d;
    end
  end

  // Reads launched before a flush still complete; CLEAR issues no reads, so the pipe drains.
  if (RD_LATENCY == 2) begin : g_rdata_flop
    logic [NUM_REQ-1:0] own2_q, own2_d;

    assign own2_d = own1_q;

    always_ff @(posedge forever_cpuclk) begin
      if (cpurst) own2_q <= '0;
      else        own2_q <= own2_d;
    end

    assign rsp_vld  = own2_q;
    assign rsp_data = rdata_q;
  end else begin : g_rdata_direct
    assign rsp_vld  = own1_q;
    assign rsp_data = (|own1_q) ? sram_q : rdata_q;
  end

endmodule

// File: tb/tb_ct_spsram_256x144_ctrl.sv
// Randomized self-checking bench for ct_spsram_256x144_ctrl against a transaction-level model.
// Honours CT_SPSRAM_CTRL_RDATA_FLOP_EN to expect read latency 2.
module tb_ct_spsram_256x144_ctrl;

  localparam int AW    = 8;
  localparam int DW    = 144;
  localparam int NR    = 2;
  localparam int DEPTH = 256;
`ifdef CT_SPSRAM_CTRL_RDATA_FLOP_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic            clk;
  logic            cpurst;
  logic            flush_req;
  logic            init_busy;
  logic [NR-1:0]   req_vld, req_wr, req_rdy, rsp_vld;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata, req_wmask;
  logic [DW-1:0]   rsp_data;
  logic [AW-1:0]   sram_a;
  logic            sram_cen, sram_gwen;
  logic [DW-1:0]   sram_wen, sram_d, sram_q;

  ct_spsram_256x144_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst         (cpurst),
    .flush_req      (flush_req),
    .init_busy      (init_busy),
    .req_vld        (req_vld),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_wmask      (req_wmask),
    .req_rdy        (req_rdy),
    .rsp_vld        (rsp_vld),
    .rsp_data       (rsp_data),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM macro: bit-write on active-low wen, read data one cycle later.
  logic [DW-1:0] sram_mem [DEPTH];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= sram_mem[sram_a];
    end
  end

  typedef struct {
    int          due;
    int          owner;
    logic [DW-1:0] data;
  } rsp_t;

  logic [DW-1:0] ref_mem [DEPTH];
  rsp_t          rspq[$];
  bit            pend_vld [NR];
  bit            pend_wr [NR];
  logic [AW-1:0] pend_addr [NR];
  logic [DW-1:0] pend_wdata [NR];
  logic [DW-1:0] pend_wmask [NR];
  int            ptr, clear_left, clr_addr, cyc;
  logic [DW-1:0] last_rsp;
  bit            last_was_read;
  int            checks = 0;
  int            errors = 0;

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] randWord();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic modelReset();
    ptr        = 0;
    clear_left = DEPTH;
    clr_addr   = 0;
    last_rsp   = '0;
    rspq.delete();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic setReq(input int i, input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] wmask);
    pend_vld[i]   = 1'b1;
    pend_wr[i]    = wr;
    pend_addr[i]  = addr;
    pend_wdata[i] = wdata;
    pend_wmask[i] = wmask;
  endtask

  task automatic applyStimulus(input int new_pct, input bit flush);
    int r;
    for (int i = 0; i < NR; i++) begin
      if (!pend_vld[i] && ($urandom_range(0, 99) < new_pct)) begin
        r = $urandom_range(0, 9);
        setReq(i, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 7)),
               randWord(),
               (r == 0) ? '0 : (r < 4) ? '1 : randWord());
      end
      req_vld[i]                = pend_vld[i];
      req_wr[i]                 = pend_wr[i];
      req_addr[i*AW +: AW]      = pend_addr[i];
      req_wdata[i*DW +: DW]     = pend_wdata[i];
      req_wmask[i*DW +: DW]     = pend_wmask[i];
    end
    flush_req = flush;
  endtask

  task automatic modelCycle();
    bit            busy;
    int            gi, idx;
    logic [NR-1:0] exp_grant, exp_vld;
    logic [DW-1:0] exp_data;
    rsp_t          e;
    busy          = (clear_left > 0);
    gi            = -1;
    exp_grant     = '0;
    last_was_read = 1'b0;
    if (!busy) begin
      for (int k = 0; k < NR; k++) begin
        idx = (ptr + k) % NR;
        if (gi < 0 && pend_vld[idx]) gi = idx;
      end
    end
    if (gi >= 0) exp_grant[gi] = 1'b1;
    checkOutput("req_rdy", DW'(req_rdy), DW'(exp_grant));
    checkOutput("init_busy", DW'(init_busy), DW'(busy));
    exp_vld  = '0;
    exp_data = last_rsp;
    if (rspq.size() > 0 && rspq[0].due == cyc) begin
      e = rspq.pop_front();
      exp_vld[e.owner] = 1'b1;
      exp_data = e.data;
      last_rsp = e.data;
    end
    checkOutput("rsp_vld", DW'(rsp_vld), DW'(exp_vld));
    checkOutput("rsp_data", rsp_data, exp_data);
    if (busy) begin
      checkOutput("clear_port", DW'({sram_cen, sram_gwen, sram_a}), DW'({2'b00, 8'(clr_addr)}));
      checkOutput("clear_d", sram_d | sram_wen, '0);
      clr_addr++;
      clear_left--;
    end else begin
      if (gi >= 0) begin
        checkOutput("grant_port", DW'({sram_cen, sram_gwen, sram_a}),
                    DW'({1'b0, !pend_wr[gi], pend_addr[gi]}));
        if (pend_wr[gi]) begin
          checkOutput("wr_wen", sram_wen, ~pend_wmask[gi]);
          checkOutput("wr_d", sram_d, pend_wdata[gi]);
          ref_mem[pend_addr[gi]] = (ref_mem[pend_addr[gi]] & ~pend_wmask[gi]) |
                                   (pend_wdata[gi] & pend_wmask[gi]);
        end else begin
          e.due = cyc + LAT;
          e.owner = gi;
          e.data = ref_mem[pend_addr[gi]];
          rspq.push_back(e);
          last_was_read = 1'b1;
        end
        ptr = (gi + 1) % NR;
        pend_vld[gi] = 1'b0;
      end else begin
        checkOutput("idle_port", DW'({sram_cen, sram_gwen}), DW'(2'b11));
      end
      if (flush_req) begin
        clear_left = DEPTH;
        clr_addr   = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      end
    end
    cyc++;
  endtask

  task automatic runCycle(input int new_pct, input bit flush);
    applyStimulus(new_pct, flush);
    #4;
    modelCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetPulse();
    cpurst    = 1'b1;
    flush_req = 1'b0;
    @(posedge clk);
    #1;
    cpurst = 1'b0;
    modelReset();
  endtask

  task automatic drain();
    for (int n = 0; n < 400; n++) begin
      if (!pend_vld[0] && !pend_vld[1]) break;
      runCycle(0, 1'b0);
    end
    if (pend_vld[0] || pend_vld[1]) checkOutput("drain_timeout", DW'(1), DW'(0));
  endtask

  initial begin
    bit found;
    cpurst    = 1'b1;
    flush_req = 1'b0;
    req_vld   = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
    cyc       = 0;
    for (int i = 0; i < NR; i++) pend_vld[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cpurst = 1'b0;
    modelReset();

    // Clear after reset with both requesters waiting, then first grants.
    for (int n = 0; n < 262; n++) runCycle(100, 1'b0);

    // Write A5 pattern from requester 0, read it back from requester 1.
    drain();
    setReq(0, 1'b1, 8'h12, {18{8'hA5}}, '1);
    runCycle(0, 1'b0);
    setReq(1, 1'b0, 8'h12, '0, '0);
    for (int n = 0; n <= LAT; n++) runCycle(0, 1'b0);
    checkOutput("t2_rdata", rsp_data, {18{8'hA5}});

    // Both requesters continuously busy: alternating grants.
    for (int n = 0; n < 6; n++) runCycle(100, 1'b0);

    // Partial-mask write over an all-ones word.
    drain();
    setReq(0, 1'b1, 8'h3C, '1, '1);
    runCycle(0, 1'b0);
    setReq(0, 1'b1, 8'h3C, '0, DW'(16'h00FF));
    runCycle(0, 1'b0);
    setReq(1, 1'b0, 8'h3C, '0, '0);
    for (int n = 0; n <= LAT; n++) runCycle(0, 1'b0);
    checkOutput("t4_rdata", rsp_data, {{(DW-8){1'b1}}, 8'h00});

    for (int n = 0; n < 400; n++) runCycle(60, ($urandom_range(0, 99) == 0));

    // Flush in the same cycle as a read grant, then re-read after the clear.
    drain();
    setReq(1, 1'b0, 8'h12, '0, '0);
    runCycle(0, 1'b1);
    for (int n = 0; n < DEPTH + 2; n++) runCycle(0, 1'b0);
    setReq(0, 1'b0, 8'h12, '0, '0);
    for (int n = 0; n <= LAT; n++) runCycle(0, 1'b0);
    checkOutput("t5_reread", rsp_data, '0);

    // Reset in the middle of a clear.
    drain();
    runCycle(0, 1'b1);
    for (int n = 0; n < 100; n++) runCycle(0, 1'b0);
    resetPulse();
    for (int n = 0; n < DEPTH + 4; n++) runCycle(0, 1'b0);

    // Reset while a read is in flight.
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      runCycle(70, 1'b0);
      found = last_was_read;
    end
    if (!found) checkOutput("find_read", DW'(0), DW'(1));
    resetPulse();
    for (int n = 0; n < DEPTH + 4; n++) runCycle(50, 1'b0);

    for (int n = 0; n < 300; n++) runCycle(60, ($urandom_range(0, 149) == 0));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
